// File: rtl/lock_pkg.sv
// Shared lock definitions: sequencing states and water-level constants in
// units of 1/56 ft, so that both the 5/8 and 5/7 ft/min rates are whole numbers.
package lock_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2,
        PAUSE = 2'd3
    } lock_state_e;

    localparam int unsigned UNITS_PER_FT = 56;
    localparam int unsigned OUTER_U      = 0;
    localparam int unsigned INNER_U      = 280;
    localparam int unsigned TOL_U        = 17;
    localparam int unsigned FILL_STEP    = 35;
    localparam int unsigned DRAIN_STEP   = 40;

endpackage

// File: rtl/sw_edge_sync.sv
// Two-flop synchronizer for an asynchronous operator switch, followed by a
// rising-edge detector that yields a single-cycle request per press.
module sw_edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic sw_i,
    output logic pulse_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Synchronizer chain plus one delay stage for the edge detector.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= sw_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign pulse_o = sync_q & ~prev_q;

endmodule

// File: rtl/lock_water_level_ctrl.sv
// Lock pound water-level engine: turns fill/drain requests into a saturating,
// time-stepped level and publishes door-openable flags, interlocked on doors.
module lock_water_level_ctrl
    import lock_pkg::*;
#(
    parameter int unsigned LEVEL_W  = 9,
    parameter int unsigned TICK_DIV = 50000000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               fill_sw,
    input  logic               drain_sw,
    input  logic               inner_door_open,
    input  logic               outer_door_open,
    output logic [LEVEL_W-1:0] level,
    output logic               outer_ok,
    output logic               inner_ok,
    output logic               filling,
    output logic               draining,
    output logic               paused,
    output logic               done,
    output logic               err
);

    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [LEVEL_W-1:0] OUTER_L  = LEVEL_W'(OUTER_U);
    localparam logic [LEVEL_W-1:0] INNER_L  = LEVEL_W'(INNER_U);
    localparam logic [LEVEL_W:0]   INNER_X  = (LEVEL_W+1)'(INNER_U);
    localparam logic [LEVEL_W:0]   FILL_X   = (LEVEL_W+1)'(FILL_STEP);
    localparam logic [LEVEL_W:0]   DRAIN_X  = (LEVEL_W+1)'(DRAIN_STEP);
    localparam logic [LEVEL_W:0]   FLOOR_X  = (LEVEL_W+1)'(OUTER_U + DRAIN_STEP);
    localparam logic [LEVEL_W:0]   OK_LO_X  = (LEVEL_W+1)'(OUTER_U + TOL_U);
    localparam logic [LEVEL_W:0]   OK_HI_X  = (LEVEL_W+1)'(INNER_U - TOL_U);

    lock_state_e        state_q, state_d;
    lock_state_e        dir_q, dir_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic               fill_req_s;
    logic               drain_req_s;
    logic               fill_only_s;
    logic               drain_only_s;
    logic               opposite_s;
    logic               door_s;
    logic               tick_s;
    logic [LEVEL_W:0]   lvl_x_s;
    logic [LEVEL_W:0]   fill_x_s;
    logic [LEVEL_W:0]   drain_x_s;
    logic [LEVEL_W-1:0] fill_lvl_s;
    logic [LEVEL_W-1:0] drain_lvl_s;
    logic [LEVEL_W-1:0] step_lvl_s;
    logic [LEVEL_W-1:0] target_s;

    sw_edge_sync u_fill_sync (
        .clk     (clk),
        .reset   (reset),
        .sw_i    (fill_sw),
        .pulse_o (fill_req_s)
    );

    sw_edge_sync u_drain_sync (
        .clk     (clk),
        .reset   (reset),
        .sw_i    (drain_sw),
        .pulse_o (drain_req_s)
    );

    assign fill_only_s  = fill_req_s & ~drain_req_s;
    assign drain_only_s = drain_req_s & ~fill_req_s;
    assign opposite_s   = (dir_q == FILL) ? drain_only_s : fill_only_s;
    assign door_s       = inner_door_open | outer_door_open;
    assign target_s     = (dir_q == FILL) ? INNER_L : OUTER_L;

    // Candidate next level for one step, computed one bit wider and clamped.
    always_comb begin
        lvl_x_s   = {1'b0, level_q};
        fill_x_s  = lvl_x_s + FILL_X;
        drain_x_s = lvl_x_s - DRAIN_X;
        if (fill_x_s > INNER_X) begin
            fill_lvl_s = INNER_L;
        end else begin
            fill_lvl_s = fill_x_s[LEVEL_W-1:0];
        end
        // A borrow out of the subtraction also means the floor was crossed.
        if (drain_x_s[LEVEL_W] || (lvl_x_s < FLOOR_X)) begin
            drain_lvl_s = OUTER_L;
        end else begin
            drain_lvl_s = drain_x_s[LEVEL_W-1:0];
        end
        if (dir_q == FILL) begin
            step_lvl_s = fill_lvl_s;
        end else begin
            step_lvl_s = drain_lvl_s;
        end
    end

    // Next-state, tick and pulse logic of the level sequencer.
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        done_d  = 1'b0;
        err_d   = fill_req_s & drain_req_s;
        tick_s  = 1'b0;

        case (state_q)
            IDLE: begin
                if (fill_only_s) begin
                    if (door_s) begin
                        err_d = 1'b1;
                    end else if (level_q == INNER_L) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = FILL;
                        dir_d   = FILL;
                        cnt_d   = '0;
                    end
                end else if (drain_only_s) begin
                    if (door_s) begin
                        err_d = 1'b1;
                    end else if (level_q == OUTER_L) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = DRAIN;
                        dir_d   = DRAIN;
                        cnt_d   = '0;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            FILL, DRAIN: begin
                // The cycle after the completing step is the one that leaves.
                if (opposite_s || (level_q == target_s)) begin
                    state_d = IDLE;
                end else if (door_s) begin
                    state_d = PAUSE;
                end else begin
                    tick_s = 1'b1;
                end
            end
            PAUSE: begin
                if (opposite_s) begin
                    state_d = IDLE;
                end else if (!door_s) begin
                    state_d = dir_q;
                    tick_s  = 1'b1;
                end else begin
                    state_d = PAUSE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (tick_s) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d   = '0;
                level_d = step_lvl_s;
                done_d  = (step_lvl_s == target_s);
            end else begin
                cnt_d   = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = cnt_d;
        end
    end

    // Sequencer state, level and pulse registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            dir_q   <= FILL;
            cnt_q   <= '0;
            level_q <= OUTER_L;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign level    = level_q;
    assign outer_ok = ({1'b0, level_q} < OK_LO_X);
    assign inner_ok = ({1'b0, level_q} > OK_HI_X);
    assign filling  = (state_q == FILL);
    assign draining = (state_q == DRAIN);
    assign paused   = (state_q == PAUSE);
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_lock_water_level_ctrl.sv
// Bench for lock_water_level_ctrl: directed vector table plus randomized
// traffic against a behavioural level model (TICK_DIV = 4).
module tb_lock_water_level_ctrl;

    localparam int TD = 4;
    localparam int M_IDLE  = 0;
    localparam int M_FILL  = 1;
    localparam int M_DRAIN = 2;
    localparam int M_PAUSE = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       fill_sw = 1'b0;
    logic       drain_sw = 1'b0;
    logic       inner_door_open = 1'b0;
    logic       outer_door_open = 1'b0;
    logic [8:0] level;
    logic       outer_ok, inner_ok, filling, draining, paused, done, err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    lock_water_level_ctrl #(.LEVEL_W(9), .TICK_DIV(TD)) dut (
        .clk             (clk),
        .reset           (reset),
        .fill_sw         (fill_sw),
        .drain_sw        (drain_sw),
        .inner_door_open (inner_door_open),
        .outer_door_open (outer_door_open),
        .level           (level),
        .outer_ok        (outer_ok),
        .inner_ok        (inner_ok),
        .filling         (filling),
        .draining        (draining),
        .paused          (paused),
        .done            (done),
        .err             (err)
    );

    // Behavioural model: mode, level in units, cycles left until next step.
    int m_level = 0, m_mode = M_IDLE, m_pdir = M_FILL, m_remain = TD;
    bit m_done = 0, m_err = 0;
    bit fh[3] = '{0, 0, 0};
    bit dh[3] = '{0, 0, 0};

    function automatic int target_of(int dir);
        return (dir == M_FILL) ? 280 : 0;
    endfunction

    task automatic m_advance(int dir);
        m_remain--;
        if (m_remain == 0) begin
            m_remain = TD;
            if (dir == M_FILL) m_level = (m_level + 35 > 280) ? 280 : m_level + 35;
            else               m_level = (m_level - 40 < 0) ? 0 : m_level - 40;
            if (m_level == target_of(dir)) m_done = 1;
        end
    endtask

    task automatic model_step();
        bit fr, dr, door;
        int want;
        m_done = 0;
        m_err  = 0;
        if (reset) begin
            m_level = 0; m_mode = M_IDLE; m_remain = TD;
            fh = '{0, 0, 0}; dh = '{0, 0, 0};
            return;
        end
        // A switch rise sampled at edge k-2 becomes a request at edge k.
        fr = fh[1] && !fh[2];
        dr = dh[1] && !dh[2];
        fh[2] = fh[1]; fh[1] = fh[0]; fh[0] = fill_sw;
        dh[2] = dh[1]; dh[1] = dh[0]; dh[0] = drain_sw;
        door = inner_door_open || outer_door_open;
        if (fr && dr) begin
            m_err = 1; fr = 0; dr = 0;
        end
        case (m_mode)
            M_IDLE: begin
                if (fr || dr) begin
                    want = fr ? M_FILL : M_DRAIN;
                    if (door) m_err = 1;
                    else if (m_level == target_of(want)) m_done = 1;
                    else begin m_mode = want; m_remain = TD; end
                end
            end
            M_FILL, M_DRAIN: begin
                if ((m_mode == M_FILL && dr) || (m_mode == M_DRAIN && fr)) m_mode = M_IDLE;
                else if (m_level == target_of(m_mode)) m_mode = M_IDLE;
                else if (door) begin m_pdir = m_mode; m_mode = M_PAUSE; end
                else m_advance(m_mode);
            end
            default: begin
                if ((m_pdir == M_FILL && dr) || (m_pdir == M_DRAIN && fr)) m_mode = M_IDLE;
                else if (!door) begin m_mode = m_pdir; m_advance(m_pdir); end
            end
        endcase
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit       rst, f, d, id, od;
        int       n;
        int       lvl;
        bit [2:0] fdp;
        bit [1:0] ok;
        int       nd, ne;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(bit rst, bit f, bit d, bit id, bit od, int n,
                                int lvl, bit [2:0] fdp, bit [1:0] ok, int nd, int ne);
        vec_t v;
        v.rst = rst; v.f = f; v.d = d; v.id = id; v.od = od; v.n = n;
        v.lvl = lvl; v.fdp = fdp; v.ok = ok; v.nd = nd; v.ne = ne;
        return v;
    endfunction

    initial begin
        int nd, ne;
        logic [15:0] act_v, exp_v;

        // rst f d id od cycles | level {fill,drain,pause} {outer_ok,inner_ok} dones errs
        vq.push_back(mk(1, 0, 0, 0, 0,  2,   0, 3'b000, 2'b10, 0, 0));
        vq.push_back(mk(0, 1, 0, 0, 0,  3,   0, 3'b100, 2'b10, 0, 0));
        vq.push_back(mk(0, 1, 0, 0, 0,  4,  35, 3'b100, 2'b00, 0, 0));
        vq.push_back(mk(0, 1, 0, 0, 0,  4,  70, 3'b100, 2'b00, 0, 0));
        vq.push_back(mk(0, 1, 0, 0, 0, 20, 245, 3'b100, 2'b00, 0, 0));
        vq.push_back(mk(0, 1, 0, 0, 0,  4, 280, 3'b100, 2'b01, 1, 0));
        vq.push_back(mk(0, 1, 0, 0, 0,  1, 280, 3'b000, 2'b01, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 0,  2, 280, 3'b000, 2'b01, 0, 0));
        vq.push_back(mk(0, 1, 0, 0, 0,  4, 280, 3'b000, 2'b01, 1, 0));
        vq.push_back(mk(0, 0, 1, 0, 0,  3, 280, 3'b010, 2'b01, 0, 0));
        vq.push_back(mk(0, 0, 1, 0, 0, 24,  40, 3'b010, 2'b00, 0, 0));
        vq.push_back(mk(0, 0, 1, 0, 0,  4,   0, 3'b010, 2'b10, 1, 0));
        vq.push_back(mk(0, 0, 1, 0, 0,  1,   0, 3'b000, 2'b10, 0, 0));
        vq.push_back(mk(0, 1, 0, 0, 1,  6,   0, 3'b000, 2'b10, 0, 1));
        vq.push_back(mk(0, 0, 0, 0, 0,  2,   0, 3'b000, 2'b10, 0, 0));
        vq.push_back(mk(0, 1, 0, 0, 0,  3,   0, 3'b100, 2'b10, 0, 0));
        vq.push_back(mk(0, 1, 0, 0, 0,  8,  70, 3'b100, 2'b00, 0, 0));
        vq.push_back(mk(0, 1, 0, 0, 0,  2,  70, 3'b100, 2'b00, 0, 0));
        vq.push_back(mk(0, 1, 0, 0, 1,  1,  70, 3'b001, 2'b00, 0, 0));
        vq.push_back(mk(0, 1, 0, 0, 1, 20,  70, 3'b001, 2'b00, 0, 0));
        vq.push_back(mk(0, 1, 0, 0, 0,  1,  70, 3'b100, 2'b00, 0, 0));
        vq.push_back(mk(0, 1, 0, 0, 0,  1, 105, 3'b100, 2'b00, 0, 0));
        vq.push_back(mk(0, 1, 1, 0, 0,  3, 105, 3'b000, 2'b00, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 0,  3, 105, 3'b000, 2'b00, 0, 0));
        vq.push_back(mk(0, 1, 1, 0, 0,  4, 105, 3'b000, 2'b00, 0, 1));
        vq.push_back(mk(0, 0, 0, 0, 0,  3, 105, 3'b000, 2'b00, 0, 0));
        vq.push_back(mk(0, 1, 0, 0, 0,  3, 105, 3'b100, 2'b00, 0, 0));
        vq.push_back(mk(0, 1, 0, 0, 0,  4, 140, 3'b100, 2'b00, 0, 0));
        vq.push_back(mk(1, 0, 0, 0, 0,  1,   0, 3'b000, 2'b10, 0, 0));
        vq.push_back(mk(0, 0, 0, 0, 0,  3,   0, 3'b000, 2'b10, 0, 0));

        foreach (vq[r]) begin
            reset           = vq[r].rst;
            fill_sw         = vq[r].f;
            drain_sw        = vq[r].d;
            inner_door_open = vq[r].id;
            outer_door_open = vq[r].od;
            nd = 0;
            ne = 0;
            for (int c = 0; c < vq[r].n; c++) begin
                cycle();
                nd += int'(done);
                ne += int'(err);
            end
            check($sformatf("row%0d level", r), int'(level), vq[r].lvl);
            check($sformatf("row%0d state/ok", r),
                  int'({filling, draining, paused, outer_ok, inner_ok}),
                  int'({vq[r].fdp, vq[r].ok}));
            check($sformatf("row%0d pulses", r), nd * 16 + ne, vq[r].nd * 16 + vq[r].ne);
        end

        // Randomized traffic, every cycle compared against the model.
        reset = 1'b1; fill_sw = 1'b0; drain_sw = 1'b0;
        inner_door_open = 1'b0; outer_door_open = 1'b0;
        cycle();
        for (int i = 0; i < 4000; i++) begin
            reset = ($urandom_range(0, 699) == 0);
            if ($urandom_range(0, 11) == 0) fill_sw = ~fill_sw;
            if ($urandom_range(0, 23) == 0) drain_sw = ~drain_sw;
            if (inner_door_open) inner_door_open = ($urandom_range(0, 7) != 0);
            else                 inner_door_open = ($urandom_range(0, 119) == 0);
            if (outer_door_open) outer_door_open = ($urandom_range(0, 7) != 0);
            else                 outer_door_open = ($urandom_range(0, 119) == 0);
            cycle();
            act_v = {level, outer_ok, inner_ok, filling, draining, paused, done, err};
            exp_v = {9'(m_level), (m_level < 17), (m_level > 263), (m_mode == M_FILL),
                     (m_mode == M_DRAIN), (m_mode == M_PAUSE), m_done, m_err};
            check($sformatf("rand cycle %0d", i), int'(act_v), int'(exp_v));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
